// File: rtl/cs_lookup_ctrl.sv
// cs_lookup_ctrl
// ---------------------------------------------------------------------------
// Decode-stage sequencer in front of the 64x23 synchronous-read ControlStore.
// Requests (6-bit address + tag) are forwarded to the ROM unconditionally;
// the ROM data returning one cycle after a fired request is captured, along
// with its tag, into a small result FIFO. Credit-based flow control ensures
// the FIFO never overflows. A flush (or reset) cancels everything buffered
// and in flight.
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   flush      discard buffered and in-flight lookups this cycle
//   in_valid   request present
//   in_ready   request accepted on in_valid && in_ready
//   in_addr    control-store address of the request
//   in_tag     tag travelling with the request
//   cs_addr    address to ControlStore (mirrors in_addr)
//   cs_bits    ControlStore read data, valid one cycle after the address
//   out_valid  result available at FIFO head
//   out_ready  consumer accepts head on out_valid && out_ready
//   out_bits   head control bits (0 when out_valid = 0)
//   out_tag    head tag (0 when out_valid = 0)
//   busy       a lookup is in flight or a result is waiting
// ---------------------------------------------------------------------------
module cs_lookup_ctrl #(
    parameter int TAG_W = 16,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_addr,
    input  logic [TAG_W-1:0] in_tag,
    output logic [5:0]       cs_addr,
    input  logic [22:0]      cs_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [22:0]      out_bits,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Result storage
    logic [22:0]      mem_bits [DEPTH];
    logic [TAG_W-1:0] mem_tag  [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             inflight_reg, inflight_next;
    logic [TAG_W-1:0] inflight_tag_reg, inflight_tag_next;

    logic             fire;
    logic             push;
    logic             pop;
    logic             clear;
    logic [CNT_W:0]   credit_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // The ROM is read every cycle; only fired addresses are ever captured.
    assign cs_addr = in_addr;

    // Credit counts both buffered results and the one still in the ROM, so a
    // capture can never find the FIFO full. Purely registered state plus the
    // reset/flush inputs; out_ready deliberately does not feed in_ready.
    assign credit_used = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
    assign in_ready    = !reset && !flush && (credit_used < (CNT_W+1)'(DEPTH));

    assign clear     = reset || flush;
    assign out_valid = !reset && (count_reg != '0);
    assign fire      = in_valid && in_ready;
    assign push      = inflight_reg && !clear;
    // A pop in a flush cycle still completes; the clear then empties the rest.
    assign pop       = out_valid && out_ready;

    assign out_bits = out_valid ? mem_bits[rd_ptr_reg] : '0;
    assign out_tag  = out_valid ? mem_tag[rd_ptr_reg]  : '0;
    assign busy     = !reset && (inflight_reg || (count_reg != '0));

    always_comb begin
        rd_ptr_next       = rd_ptr_reg;
        wr_ptr_next       = wr_ptr_reg;
        count_next        = count_reg;
        inflight_next     = fire;
        inflight_tag_next = inflight_tag_reg;

        if (fire) begin
            inflight_tag_next = in_tag;
        end
        if (push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        if (clear) begin
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            count_next    = '0;
            inflight_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            count_reg        <= '0;
            inflight_reg     <= 1'b0;
            inflight_tag_reg <= '0;
        end else begin
            rd_ptr_reg       <= rd_ptr_next;
            wr_ptr_reg       <= wr_ptr_next;
            count_reg        <= count_next;
            inflight_reg     <= inflight_next;
            inflight_tag_reg <= inflight_tag_next;
        end
    end

    // Storage carries no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_bits[wr_ptr_reg] <= cs_bits;
            mem_tag[wr_ptr_reg]  <= inflight_tag_reg;
        end
    end

endmodule
